// File: rtl/odev1_pkg.sv
// Shared types and constants for the odev1 truth-table checker.
package odev1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int N_COMB   = 8;
    localparam int N_CHECKS = 16;

    localparam logic [7:0] DEF_EXP_F = 8'hFE;
    localparam logic [7:0] DEF_EXP_Q = 8'hFF;

    localparam logic [4:0] CHECKS_FULL = 5'(N_CHECKS);
    localparam logic [2:0] LAST_IDX    = 3'(N_COMB - 1);

    function automatic logic [1:0] hit_count(logic mf, logic mq);
        return {1'b0, mf} + {1'b0, mq};
    endfunction

endpackage

// File: rtl/odev1_karsilastirici.sv
// Combinational comparator: checks F and Q of one input
// combination against the expected tables.
module odev1_karsilastirici
    import odev1_pkg::*;
(
    input  logic [2:0] idx,
    input  logic       dut_f,
    input  logic       dut_q,
    input  logic [7:0] exp_f,
    input  logic [7:0] exp_q,
    output logic       match_f,
    output logic       match_q,
    output logic       any_fail
);

    assign match_f  = (dut_f == exp_f[idx]);
    assign match_q  = (dut_q == exp_q[idx]);
    assign any_fail = !(match_f && match_q);

endmodule

// File: rtl/odev1_denetleyici.sv
// Sweeps all eight {A,B,C} combinations through the checked block,
// samples F and Q after settling and accumulates pass/fail results.
module odev1_denetleyici
    import odev1_pkg::*;
#(
    parameter logic [7:0] EXP_F      = DEF_EXP_F,
    parameter logic [7:0] EXP_Q      = DEF_EXP_Q,
    parameter int         SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    input  logic       dut_f,
    input  logic       dut_q,
    output logic       busy,
    output logic       done,
    output logic [4:0] pass_cnt,
    output logic [4:0] fail_cnt,
    output logic       all_pass,
    output logic       all_fail,
    output logic [2:0] first_fail_idx,
    output logic       first_fail_vld
);

    localparam logic [3:0] WAIT_INIT = 4'(SETTLE_CYC - 1);

    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic [3:0] wcnt, wcnt_n;
    logic [4:0] pass_n, fail_n;
    logic [2:0] ffi_n;
    logic       ffv_n;
    logic       busy_n, done_n;

    logic       match_f, match_q, any_fail;
    logic [1:0] hits;

    odev1_karsilastirici u_cmp (
        .idx      (idx),
        .dut_f    (dut_f),
        .dut_q    (dut_q),
        .exp_f    (EXP_F),
        .exp_q    (EXP_Q),
        .match_f  (match_f),
        .match_q  (match_q),
        .any_fail (any_fail)
    );

    assign hits = hit_count(match_f, match_q);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        wcnt_n  = wcnt;
        pass_n  = pass_cnt;
        fail_n  = fail_cnt;
        ffi_n   = first_fail_idx;
        ffv_n   = first_fail_vld;
        busy_n  = busy;
        done_n  = done;
        unique case (state)
            IDLE, DONE: begin
                // first_fail_idx keeps its old value; only the valid flag clears
                if (start) begin
                    state_n = SETTLE;
                    idx_n   = '0;
                    wcnt_n  = WAIT_INIT;
                    pass_n  = '0;
                    fail_n  = '0;
                    ffv_n   = 1'b0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                end
            end
            SETTLE: begin
                if (wcnt == '0) begin
                    state_n = SAMPLE;
                end else begin
                    wcnt_n = wcnt - 4'd1;
                end
            end
            SAMPLE: begin
                pass_n = pass_cnt + {3'b000, hits};
                fail_n = fail_cnt + {3'b000, 2'd2 - hits};
                if (any_fail && !first_fail_vld) begin
                    ffi_n = idx;
                    ffv_n = 1'b1;
                end
                if (idx == LAST_IDX) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n = SETTLE;
                    idx_n   = idx + 3'd1;
                    wcnt_n  = WAIT_INIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            wcnt           <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            wcnt           <= wcnt_n;
            pass_cnt       <= pass_n;
            fail_cnt       <= fail_n;
            first_fail_idx <= ffi_n;
            first_fail_vld <= ffv_n;
            busy           <= busy_n;
            done           <= done_n;
        end
    end

    assign dut_a = idx[2];
    assign dut_b = idx[1];
    assign dut_c = idx[0];

    assign all_pass = done && (pass_cnt == CHECKS_FULL);
    assign all_fail = done && (fail_cnt == CHECKS_FULL);

endmodule

// File: tb/tb_odev1_denetleyici.sv
// Bench for odev1_denetleyici: two instances (SETTLE_CYC 2 and 1)
// checked every cycle against a time-since-start model.
module tb_odev1_denetleyici;

    localparam logic [7:0] EXP_F = 8'hFE;
    localparam logic [7:0] EXP_Q = 8'hFF;
    localparam int SC0 = 2;
    localparam int SC1 = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] a, b, c, f, q;
    logic [1:0] busy, done, ap, af, ffv;
    logic [4:0] pc [2];
    logic [4:0] fc [2];
    logic [2:0] ffi [2];

    int mode = 0;
    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    odev1_denetleyici u0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(a[0]), .dut_b(b[0]), .dut_c(c[0]),
        .dut_f(f[0]), .dut_q(q[0]),
        .busy(busy[0]), .done(done[0]),
        .pass_cnt(pc[0]), .fail_cnt(fc[0]),
        .all_pass(ap[0]), .all_fail(af[0]),
        .first_fail_idx(ffi[0]), .first_fail_vld(ffv[0])
    );

    odev1_denetleyici #(.SETTLE_CYC(SC1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(a[1]), .dut_b(b[1]), .dut_c(c[1]),
        .dut_f(f[1]), .dut_q(q[1]),
        .busy(busy[1]), .done(done[1]),
        .pass_cnt(pc[1]), .fail_cnt(fc[1]),
        .all_pass(ap[1]), .all_fail(af[1]),
        .first_fail_idx(ffi[1]), .first_fail_vld(ffv[1])
    );

    // Checked-block models: 0 correct, 1 F stuck at 0, 2 F and Q inverted
    function automatic logic fm(int md, int i);
        if (md == 1) return 1'b0;
        if (md == 2) return (i == 0);
        return (i != 0);
    endfunction

    function automatic logic qm(int md);
        return (md == 2) ? 1'b0 : 1'b1;
    endfunction

    always_comb begin
        f[0] = fm(mode, int'({a[0], b[0], c[0]}));
        q[0] = qm(mode);
        f[1] = fm(0, int'({a[1], b[1], c[1]}));
        q[1] = qm(0);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Results after the first kk combinations of a sweep have been sampled
    task automatic eval(input int md, input int kk, output int p,
                        output int fl, output bit v, output int fi);
        p = 0; fl = 0; v = 0; fi = 0;
        for (int i = 0; i < kk; i++) begin
            bit mf, mq;
            mf = (fm(md, i) == EXP_F[i]);
            mq = (qm(md) == EXP_Q[i]);
            p  += int'(mf) + int'(mq);
            fl += 2 - int'(mf) - int'(mq);
            if ((!mf || !mq) && !v) begin
                v = 1; fi = i;
            end
        end
    endtask

    bit run_m [2];
    bit done_m [2];
    int n_m [2];
    int md_m [2];
    int ffi_m [2];

    function automatic int per(int k);
        return (k == 0) ? SC0 + 1 : SC1 + 1;
    endfunction

    function automatic int sampled(int k);
        if (run_m[k]) return n_m[k] / per(k);
        return done_m[k] ? 8 : 0;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            run_m[k] = 0; done_m[k] = 0; n_m[k] = 0;
            md_m[k] = 0; ffi_m[k] = 0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                int p, fl, fi;
                bit v;
                if (!rst_n) begin
                    run_m[k] = 0; done_m[k] = 0; n_m[k] = 0; ffi_m[k] = 0;
                end else if (start && !run_m[k]) begin
                    run_m[k] = 1; done_m[k] = 0; n_m[k] = 0;
                    md_m[k] = (k == 0) ? mode : 0;
                end else if (run_m[k]) begin
                    n_m[k]++;
                    if (n_m[k] == 8 * per(k)) begin
                        run_m[k] = 0; done_m[k] = 1;
                    end
                end
                eval(md_m[k], sampled(k), p, fl, v, fi);
                if (v) ffi_m[k] = fi;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int p, fl, fi, ix;
                bit v;
                eval(md_m[k], sampled(k), p, fl, v, fi);
                ix = run_m[k] ? n_m[k] / per(k) : (done_m[k] ? 7 : 0);
                chk($sformatf("idx%0d", k), 32'({a[k], b[k], c[k]}), 32'(ix));
                chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(run_m[k]));
                chk($sformatf("done%0d", k), 32'(done[k]), 32'(done_m[k]));
                chk($sformatf("pass%0d", k), 32'(pc[k]), 32'(p));
                chk($sformatf("fail%0d", k), 32'(fc[k]), 32'(fl));
                chk($sformatf("ffv%0d", k), 32'(ffv[k]), 32'(v));
                chk($sformatf("ffi%0d", k), 32'(ffi[k]), 32'(ffi_m[k]));
                chk($sformatf("allp%0d", k), 32'(ap[k]), 32'(done_m[k] && p == 16));
                chk($sformatf("allf%0d", k), 32'(af[k]), 32'(done_m[k] && fl == 16));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input bit rep, output int l0, output int l1);
        int cnt;
        cnt = 0; l0 = -1; l1 = -1;
        while (l0 < 0 && cnt < 60) begin
            if (done[1] === 1'b1 && l1 < 0) l1 = cnt;
            if (done[0] === 1'b1) begin
                l0 = cnt;
            end else begin
                @(negedge clk);
                cnt++;
                if (rep && cnt == 4) start = 1'b1;
                if (rep && cnt == 5) start = 1'b0;
            end
        end
        chk("lat_settle2", 32'(l0), 32'd24);
        chk("lat_settle1", 32'(l1), 32'd16);
    endtask

    task automatic lit(string nm, int p, int fl, bit apx, bit afx, bit v, int fi);
        chk({nm, "_pass"}, 32'(pc[0]), 32'(p));
        chk({nm, "_fail"}, 32'(fc[0]), 32'(fl));
        chk({nm, "_allp"}, 32'(ap[0]), 32'(apx));
        chk({nm, "_allf"}, 32'(af[0]), 32'(afx));
        chk({nm, "_ffv"}, 32'(ffv[0]), 32'(v));
        if (v) chk({nm, "_ffi"}, 32'(ffi[0]), 32'(fi));
        chk({nm, "_s1pass"}, 32'(pc[1]), 32'd16);
    endtask

    initial begin
        int l0, l1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_pass", 32'(pc[0]), 32'd0);
        chk("rst_idx", 32'({a[0], b[0], c[0]}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mode = 0;
        pulse_start();
        wait_done(1'b0, l0, l1);
        lit("good", 16, 0, 1, 0, 0, 0);

        mode = 1;
        pulse_start();
        wait_done(1'b0, l0, l1);
        lit("stuck", 9, 7, 0, 0, 1, 1);

        mode = 2;
        pulse_start();
        wait_done(1'b0, l0, l1);
        lit("inv", 0, 16, 0, 1, 1, 0);

        mode = 0;
        pulse_start();
        wait_done(1'b1, l0, l1);
        lit("repulse", 16, 0, 1, 0, 0, 0);
        pulse_start();
        wait_done(1'b0, l0, l1);
        lit("restart", 16, 0, 1, 0, 0, 0);

        mode = 1;
        pulse_start();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_busy", 32'(busy[0]), 32'd0);
        chk("mid_done", 32'(done[0]), 32'd0);
        chk("mid_pass", 32'(pc[0]), 32'd0);
        chk("mid_fail", 32'(fc[0]), 32'd0);
        chk("mid_idx", 32'({a[0], b[0], c[0]}), 32'd0);
        chk("mid_ffv", 32'(ffv[0]), 32'd0);
        repeat (2) @(negedge clk);
        mode = 0;
        pulse_start();
        wait_done(1'b0, l0, l1);
        lit("postrst", 16, 0, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/odev1_denetleyici.md
Name: odev1_denetleyici

Overview:
- Sequential stimulus-and-check stage wrapped around the combinational block with inputs A, B, C and outputs F, Q.
- Drives all 8 input combinations in ascending order, waits for settling, samples F and Q, and compares them against parameterised expected truth tables.
- Accumulates pass/fail counts and reports the result.
- Synthesisable, so the hardware replaces the simulation-only check loop.

Parameters:
- EXP_F, 8'hFE, expected F per combination; bit i = expected F when {A,B,C}=i.
- EXP_Q, 8'hFF, expected Q per combination; same indexing.
- SETTLE_CYC, 2, cycles held after each input change before sampling (legal range 1..15).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
- dut_a  out  1  A input to the checked block (MSB of index).
- dut_b  out  1  B input.
- dut_c  out  1  C input (LSB of index).
- dut_f  in  1  F output from the checked block.
- dut_q  in  1  Q output from the checked block.
- busy  out  1  high from the cycle after start until the sweep completes.
- done  out  1  high in DONE state; held until the next start or reset.
- pass_cnt  out  5  number of matching checks (0..16).
- fail_cnt  out  5  number of mismatching checks (0..16).
- all_pass  out  1  done & (pass_cnt==16).
- all_fail  out  1  done & (fail_cnt==16).
- first_fail_idx  out  3  index of the first combination with any mismatch.
- first_fail_vld  out  1  first_fail_idx is valid.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE. idx=0, dut_a/b/c=0, busy=0, done=0, counters=0, first_fail_idx=0, first_fail_vld=0. Reset has priority over everything, including mid-sweep; a partial sweep is discarded.
- {dut_a,dut_b,dut_c} is always the registered idx, with no combinational path from inputs.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE.
  - On the same edge: idx=0, counters clear, first_fail_vld=0, wait counter=SETTLE_CYC-1, busy=1.
- SETTLE:
  - Decrement the wait counter each cycle.
  - When it is 0 -> SAMPLE.
  - Inputs are held stable for exactly SETTLE_CYC cycles before sampling.
- SAMPLE (one cycle): compare dut_f with EXP_F[idx] and dut_q with EXP_Q[idx]. Each check adds 1 to pass_cnt or fail_cnt, so 2 increments per cycle.
  - If either check mismatches and first_fail_vld=0: latch first_fail_idx=idx and set first_fail_vld=1.
  - If idx==7 -> DONE with busy=0 and done=1; idx stays 7 and does not wrap.
  - Otherwise idx=idx+1, reload the wait counter, -> SETTLE.
- Sweep latency: start edge to done=1 is 8*(SETTLE_CYC+1) cycles. With the default SETTLE_CYC=2 this is 24 cycles.
- DONE:
  - Outputs are frozen.
  - start=1 -> same action as IDLE+start: new sweep, results cleared, done drops the next cycle.
- start while busy is ignored and has no side effects.
- Invariant: pass_cnt + fail_cnt = 2 × (combinations sampled). At done this is always 16. The counters cannot overflow (5 bits, max 16).
- dut_f and dut_q are sampled only in SAMPLE; X or changes outside SAMPLE have no effect.

Decomposition:
- Shared package odev1_pkg holds:
  - state encoding constants (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - N_COMB=8;
  - N_CHECKS=16;
  - default expected tables 8'hFE and 8'hFF.
- One natural sub-module: odev1_karsilastirici. It is the combinational comparator: takes idx, dut_f, dut_q and the tables, and returns match_f, match_q and any_fail.
- The FSM, counters and first-fail latch stay in the top module.

Test Plan:
- Correct DUT model (F=A|B|C, Q=1), default parameters, pulse start -> done at cycle 24, pass_cnt=16, fail_cnt=0, all_pass=1, first_fail_vld=0. Inputs step through 0..7, each held 3 cycles.
- Model with F stuck at 0 -> pass_cnt=9, fail_cnt=7, first_fail_idx=1, first_fail_vld=1, all_pass=0.
- Model inverting both F and Q -> fail_cnt=16, pass_cnt=0, all_fail=1, first_fail_idx=0.
- start re-pulsed at cycle 5 of a sweep -> ignored, done still at cycle 24, counts unchanged. Then start in DONE -> counters clear, new sweep completes 24 cycles later.
- rst_n=0 for one cycle at cycle 10 -> next cycle: state IDLE, busy=0, done=0, counts=0, dut inputs=0. A subsequent start produces a full clean sweep.
- SETTLE_CYC=1 with correct model -> done after 16 cycles, pass_cnt=16.
